uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_rr_pick.sv | 39 +++
 rtl/uart_tx_arbiter.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
// Latency: none (declarations only).
// Backpressure: not applicable.
package uart_pkg;

    // Arbiter FSM: IDLE picks a requester, LOCKED streams its message.
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // Width of a port index; never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Round-robin picker: first requesting port scanning ptr, ptr+1, ... mod NUM_PORTS.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the pick.
module uart_rr_pick #(
    parameter int NUM_PORTS = 4,
    parameter int IW        = 2
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IW-1:0]        ptr,
    output logic [IW-1:0]        grant,
    output logic                 any_req
);

    localparam int SW = IW + 1;

    logic [2*NUM_PORTS-1:0] dbl;
    logic [NUM_PORTS-1:0]   rot;
    logic [IW-1:0]          off;
    logic [SW-1:0]          sum;

    // Rotate requests so ptr sits at bit 0, find the lowest set bit, then undo the rotation.
    always_comb begin
        dbl = {req, req} >> ptr;
        rot = dbl[NUM_PORTS-1:0];
        off = '0;
        for (int j = NUM_PORTS - 1; j >= 0; j--) begin
            if (rot[j]) begin
                off = IW'(j);
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= SW'(NUM_PORTS)) begin
            sum = sum - SW'(NUM_PORTS);
        end
        grant   = sum[IW-1:0];
        any_req = |req;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter merging NUM_PORTS AXI-stream requesters onto one UART transmit stream.
// Latency: request seen at N, beat accepted at N+1, m_axis_tvalid at N+2; then 1 beat/cycle.
// Backpressure: granted s_axis_tready = !m_axis_tvalid || m_axis_tready, all others held at 0.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_PORTS  = 4,
    parameter int TIMEOUT    = 1024
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
    input  logic [NUM_PORTS-1:0]            s_axis_tlast,
    output logic [NUM_PORTS-1:0]            s_axis_tready,
    output logic [DATA_WIDTH-1:0]           m_axis_tdata,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic [idx_w(NUM_PORTS)-1:0]     m_axis_tid,
    output logic                            m_axis_tlast,
    output logic                            busy,
    output logic                            lock_timeout
);

    localparam int IW = idx_w(NUM_PORTS);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    arb_state_t            state_q, state_d;
    logic [IW-1:0]         grant_idx, grant_d;
    logic [IW-1:0]         rr_ptr, rr_d;
    logic [CW-1:0]         idle_cnt, idle_d;
    logic                  lock_timeout_d;
    logic [IW-1:0]         pick_idx;
    logic                  any_req;
    logic                  out_free;
    logic                  accept;
    logic                  gnt_vld;
    logic                  gnt_last;
    logic [DATA_WIDTH-1:0] gnt_dat;
    logic [IW-1:0]         next_ptr;

    uart_rr_pick #(
        .NUM_PORTS(NUM_PORTS),
        .IW       (IW)
    ) u_pick (
        .req    (s_axis_tvalid),
        .ptr    (rr_ptr),
        .grant  (pick_idx),
        .any_req(any_req)
    );

    // Output register can take a beat when empty or draining this cycle.
    assign out_free = !m_axis_tvalid || m_axis_tready;
    assign accept   = (state_q == LOCKED) && gnt_vld && out_free;
    assign busy     = (state_q == LOCKED) || m_axis_tvalid;
    assign next_ptr = (grant_idx == IW'(NUM_PORTS - 1)) ? '0 : grant_idx + 1'b1;

    // Mux the granted requester onto a single beat.
    always_comb begin
        gnt_vld  = 1'b0;
        gnt_dat  = '0;
        gnt_last = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant_idx == IW'(i)) begin
                gnt_vld  = s_axis_tvalid[i];
                gnt_dat  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                gnt_last = s_axis_tlast[i];
            end
        end
    end

    // Only the locked requester sees ready; nothing is accepted while choosing.
    always_comb begin
        s_axis_tready = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            s_axis_tready[i] = (state_q == LOCKED) && (grant_idx == IW'(i)) && out_free;
        end
    end

    // Next-state: grant in IDLE, release on tlast or after TIMEOUT idle cycles.
    always_comb begin
        state_d        = state_q;
        grant_d        = grant_idx;
        rr_d           = rr_ptr;
        idle_d         = idle_cnt;
        lock_timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d = pick_idx;
                    idle_d  = '0;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (accept) begin
                    idle_d = '0;
                    if (gnt_last) begin
                        state_d = IDLE;
                        rr_d    = next_ptr;
                    end
                end else if (!gnt_vld) begin
                    // A stalled but valid requester is waiting on us, so only a silent one ages.
                    if ((TIMEOUT > 0) && (idle_cnt == CW'(TIMEOUT - 1))) begin
                        state_d        = IDLE;
                        rr_d           = next_ptr;
                        idle_d         = '0;
                        lock_timeout_d = 1'b1;
                    end else begin
                        idle_d = idle_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Arbitration state; rst_n assertion is asynchronous, its release is expected aligned to clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_idx    <= '0;
            rr_ptr       <= '0;
            idle_cnt     <= '0;
            lock_timeout <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_idx    <= grant_d;
            rr_ptr       <= rr_d;
            idle_cnt     <= idle_d;
            lock_timeout <= lock_timeout_d;
        end
    end

    // Output holding register: a new beat wins over the handshake that empties it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tid    <= '0;
            m_axis_tlast  <= 1'b0;
        end else if (accept) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= gnt_dat;
            m_axis_tid    <= grant_idx;
            m_axis_tlast  <= gnt_last;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

endmodule
